// File: rtl/boundflasher_pkg.sv
// -----------------------------------------------------------------------------
// boundflasher_pkg
// Shared definitions for the BoundFlasher lamp-index counter path.
//   CNT_WIDTH : width of the lamp index (indices 0..31)
//   CNT_RESET : index the counter returns to on reset
//   cnt_t     : lamp-index type shared by the state register and the
//               upstream next-state logic
// -----------------------------------------------------------------------------
package boundflasher_pkg;

    localparam int unsigned CNT_WIDTH = 5;
    localparam logic [CNT_WIDTH-1:0] CNT_RESET = 5'b00000;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

endpackage : boundflasher_pkg

// File: rtl/counter_reg_chk.sv
// -----------------------------------------------------------------------------
// counter_reg_chk
// Simulation-only property checker for counter_reg; instantiated alongside
// the register and observes its ports only.
//   - counter equals the reset value whenever rst_n is low at a clock edge
//   - counter equals counter_n from the previous edge whenever that edge was
//     a real capture (rst_n high, no reset pulse since)
// Ports: clk, rst_n, counter_n, counter -- all inputs, mirroring counter_reg.
// -----------------------------------------------------------------------------
module counter_reg_chk
    import boundflasher_pkg::*;
#(
    parameter int          WIDTH       = CNT_WIDTH,
    parameter logic [31:0] RESET_VALUE = 32'(CNT_RESET)
) (
    input logic             clk,
    input logic             rst_n,
    input logic [WIDTH-1:0] counter_n,
    input logic [WIDTH-1:0] counter
);

    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

    // Set once a clock edge has been taken with rst_n high; any reset pulse,
    // even one shorter than a cycle, clears it so the next edge is not
    // judged against a value that the reset wiped out.
    logic capture_valid_r;

    // Tracks whether the previous edge was a genuine capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capture_valid_r <= 1'b0;
        end else begin
            capture_valid_r <= 1'b1;
        end
    end

    a_reset_value: assert property (@(posedge clk) !rst_n |-> (counter == RST_VAL));

    a_one_cycle_capture: assert property (
        @(posedge clk) (capture_valid_r && rst_n) |-> (counter == $past(counter_n))
    );

endmodule : counter_reg_chk

// File: rtl/counter_reg.sv
// -----------------------------------------------------------------------------
// counter_reg
// State register for the BoundFlasher lamp-index counter. Captures the
// next-state value from the upstream FSM on every rising clock edge and
// presents it, straight from the flops, to the flasher datapath.
// No arithmetic lives here: increment, decrement and wrap are upstream.
//
// Parameters:
//   WIDTH       : counter width (default CNT_WIDTH = 5)
//   RESET_VALUE : value loaded while rst_n is low; carried 32 bits wide so
//                 that an out-of-range value can be detected at elaboration
// Ports:
//   clk       in   1      system clock, rising-edge active
//   rst_n     in   1      asynchronous active-low reset
//   counter_n in   WIDTH  next-state counter value
//   counter   out  WIDTH  registered counter value
// -----------------------------------------------------------------------------
module counter_reg
    import boundflasher_pkg::*;
#(
    parameter int          WIDTH       = CNT_WIDTH,
    parameter logic [31:0] RESET_VALUE = 32'(CNT_RESET)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] counter_n,
    output logic [WIDTH-1:0] counter
);

    // Reset value narrowed to the register width once the range check passes.
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 1) begin : g_bad_width
        $error("counter_reg: WIDTH must be at least 1");
    end
    if ((RESET_VALUE >> WIDTH) != 32'd0) begin : g_bad_reset_value
        $error("counter_reg: RESET_VALUE does not fit in WIDTH bits");
    end

    // Lamp-index state register: async reset to RST_VAL, else full-width capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= RST_VAL;
        end else begin
            counter <= counter_n;
        end
    end

endmodule : counter_reg

// File: tb/tb_counter_reg.sv
// -----------------------------------------------------------------------------
// tb_counter_reg
// Self-checking bench for counter_reg: scoreboard queue of expected capture
// values, a vector table for sequence tracking, and hand-written sequences
// for asynchronous reset, reset release and glitch immunity.
// -----------------------------------------------------------------------------
module tb_counter_reg;
    import boundflasher_pkg::*;

    typedef struct {
        cnt_t din;
        cnt_t exp;
    } vec_t;

    logic clk;
    logic rst_n;
    cnt_t counter_n;
    cnt_t counter;
    logic clk_run;

    int checks;
    int errors;
    cnt_t last_exp;
    cnt_t sb_q[$];
    vec_t vecs[33];

    counter_reg #(
        .WIDTH      (CNT_WIDTH),
        .RESET_VALUE(32'(CNT_RESET))
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .counter_n(counter_n),
        .counter  (counter)
    );

    counter_reg_chk #(
        .WIDTH      (CNT_WIDTH),
        .RESET_VALUE(32'(CNT_RESET))
    ) chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .counter_n(counter_n),
        .counter  (counter)
    );

    // Gated free-running clock, period 10; held static until clk_run is set.
    always #5 if (clk_run) clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input cnt_t act, input cnt_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Pops the oldest expected value and compares it with the DUT output.
    task automatic sb_check(input string name);
        cnt_t exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty at %0t", name, $time);
        end else begin
            exp = sb_q.pop_front();
            check(name, counter, exp);
            last_exp = exp;
        end
    endtask

    // Drives one value mid-cycle, confirms the output holds until the edge,
    // then confirms the capture one edge later.
    task automatic apply(input cnt_t din, input cnt_t exp, input string name);
        @(negedge clk);
        counter_n = din;
        sb_q.push_back(exp);
        #1;
        check({name, "_hold"}, counter, last_exp);
        @(posedge clk);
        #1;
        sb_check(name);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        clk      = 1'b0;
        clk_run  = 1'b0;
        rst_n    = 1'b1;
        counter_n = 5'b10101;
        last_exp = 5'b00000;

        for (int i = 0; i < 33; i++) begin
            vecs[i].din = cnt_t'(i % 32);
            vecs[i].exp = cnt_t'(i % 32);
        end

        // Asynchronous reset with the clock held static.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_no_clk", counter, 5'b00000);

        // Reset dominance over three clock edges.
        counter_n = 5'b11111;
        clk_run   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_dominance", counter, 5'b00000);
        end

        // Release mid-cycle; capture only at the following rising edge.
        @(negedge clk);
        counter_n = 5'b00011;
        rst_n     = 1'b1;
        #1;
        check("release_no_change", counter, 5'b00000);
        sb_q.push_back(5'b00011);
        @(posedge clk);
        #1;
        sb_check("first_capture");

        // Sequence tracking 0..31 then 0, one cycle latency each.
        for (int i = 0; i < 33; i++) begin
            apply(vecs[i].din, vecs[i].exp, $sformatf("seq_%0d", i));
        end

        // Mid-operation reset pulse of half a cycle.
        apply(5'b01010, 5'b01010, "preload");
        counter_n = 5'b01100;
        rst_n = 1'b0;
        #1;
        check("midop_reset_async", counter, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midop_release_hold", counter, 5'b00000);
        sb_q.push_back(5'b01100);
        @(posedge clk);
        #1;
        sb_check("midop_reload");

        // Glitch immunity: only the value settled before the edge is captured.
        @(negedge clk);
        counter_n = 5'b00001;
        #1;
        check("glitch_hold_a", counter, last_exp);
        counter_n = 5'b00010;
        #1;
        check("glitch_hold_b", counter, last_exp);
        counter_n = 5'b00100;
        #1;
        counter_n = 5'b00111;
        sb_q.push_back(5'b00111);
        @(posedge clk);
        #1;
        sb_check("glitch_capture");
        counter_n = 5'b11000;
        @(negedge clk);
        check("glitch_stable", counter, 5'b00111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_counter_reg
